hazard_flush_controller: RTL and testbench



---
 rtl/hazard_pkg.sv | 33 +++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_flush_controller.sv | 155 +++++++++++++++
 tb/tb_hazard_flush_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/flush controller.
//   state_e  : branch-freeze FSM states (RUN, WAIT)
//   slot_t   : one scoreboard entry {valid, destination register}
//   make_slot: builds an entry; writes to $0 never become valid
//   slot_hit : true when a valid entry names the given register
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] regnum;
    } slot_t;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam logic [1:0] CTRL_WAIT_CYCLES = 2'd1;
    localparam slot_t      SLOT_INVALID     = '{valid: 1'b0, regnum: 5'd0};

    function automatic slot_t make_slot(input logic wr, input logic [4:0] r);
        slot_t s;
        s.valid  = wr && (r != REG_ZERO);
        s.regnum = r;
        return s;
    endfunction

    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.valid && (s.regnum == r);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   Clk, Reset : clock and synchronous active-high clear
//   inc        : count enable for this cycle
//   count      : registered count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count register with saturation at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_flush_controller.sv
// Pipeline sequencing controller for a 5-stage MIPS datapath without
// forwarding. Tracks in-flight destination registers (EX/MEM/WB), stalls
// ID on RAW hazards and handles MEM-resolved control transfers either by
// squashing (BRANCH_POLICY=0) or by freezing fetch (BRANCH_POLICY=1).
//   Inputs : Clk, Reset, ID operand/destination info, id_is_ctrl, pc_src
//   Outputs: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush
//            (combinational), stall_cycles/flush_events (registered)
module hazard_flush_controller
    import hazard_pkg::*;
#(
    parameter int BRANCH_POLICY  = 0,
    parameter int WB_WRITE_FIRST = 1,
    parameter int CNT_W          = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dest,
    input  logic             id_is_ctrl,
    input  logic             pc_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam bit FREEZE   = (BRANCH_POLICY != 32'sd0);
    localparam bit WB_CHECK = (WB_WRITE_FIRST == 32'sd0);

    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_d, mem_d, wb_d;
    state_e     state_q;
    logic [1:0] cnt_q;

    logic hit_rs, hit_rt, raw, in_wait, issue, go_wait, stall_inc;

    // Hazard detection and issue decision.
    always_comb begin
        hit_rs = slot_hit(ex_q, id_rs) || slot_hit(mem_q, id_rs) ||
                 (WB_CHECK && slot_hit(wb_q, id_rs));
        hit_rt = slot_hit(ex_q, id_rt) || slot_hit(mem_q, id_rt) ||
                 (WB_CHECK && slot_hit(wb_q, id_rt));
        raw = (id_uses_rs && (id_rs != REG_ZERO) && hit_rs) ||
              (id_uses_rt && (id_rt != REG_ZERO) && hit_rt);
        in_wait   = (state_q == WAIT);
        issue     = !raw && !pc_src && !in_wait;
        go_wait   = FREEZE && issue && id_is_ctrl;
        // In WAIT the ID stage holds a NOP, so a matching operand is not a stall.
        stall_inc = raw && !pc_src && !in_wait;
    end

    // Scoreboard next state; a redirect kills the instruction heading for MEM.
    always_comb begin
        wb_d  = mem_q;
        mem_d = pc_src ? SLOT_INVALID : ex_q;
        ex_d  = issue ? make_slot(id_reg_write, id_dest) : SLOT_INVALID;
    end

    // Stage controls.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (Reset) begin
            pc_write = 1'b1;
        end else if (!FREEZE) begin
            if (pc_src) begin
                // Redirect outranks a simultaneous stall.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end else if (raw) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end else begin
            if (in_wait) begin
                // cnt_q==0: the control instruction is in MEM and resolves now.
                pc_write   = (cnt_q == 2'd0);
                ifid_flush = (cnt_q == 2'd0) ? pc_src : 1'b1;
            end else if (stall_inc) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (go_wait) begin
                // Hold PC at ctrl+4 and feed NOPs until the branch resolves.
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end
    end

    // Scoreboard registers and freeze FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q    <= SLOT_INVALID;
            mem_q   <= SLOT_INVALID;
            wb_q    <= SLOT_INVALID;
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            case (state_q)
                RUN: begin
                    if (go_wait) begin
                        state_q <= WAIT;
                        cnt_q   <= CTRL_WAIT_CYCLES;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (pc_src),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed bench for hazard_flush_controller. Three instances share one
// stimulus stream: u0 squash/WB-write-first with 3-bit counters (for
// saturation), u1 squash with WB slot checked, u2 fetch-freeze policy.
// Control vectors are packed {pc_write, ifid_write, ifid_flush,
// idex_bubble, exmem_flush}.
module tb_hazard_flush_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_dest = 5'd0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0;
    logic       id_is_ctrl = 1'b0, pc_src = 1'b0;

    logic        pw0, iw0, if0, ib0, ef0;
    logic        pw1, iw1, if1, ib1, ef1;
    logic        pw2, iw2, if2, ib2, ef2;
    logic [2:0]  sc0, fe0;
    logic [31:0] sc1, fe1, sc2, fe2;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_SQ    = 5'b11111;
    localparam logic [4:0] C_FRZ   = 5'b01100;
    localparam logic [4:0] C_TAKEN = 5'b11100;

    hazard_flush_controller #(.BRANCH_POLICY(0), .WB_WRITE_FIRST(1), .CNT_W(3)) u0 (
        .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_is_ctrl(id_is_ctrl), .pc_src(pc_src),
        .pc_write(pw0), .ifid_write(iw0), .ifid_flush(if0), .idex_bubble(ib0),
        .exmem_flush(ef0), .stall_cycles(sc0), .flush_events(fe0));

    hazard_flush_controller #(.BRANCH_POLICY(0), .WB_WRITE_FIRST(0), .CNT_W(32)) u1 (
        .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_is_ctrl(id_is_ctrl), .pc_src(pc_src),
        .pc_write(pw1), .ifid_write(iw1), .ifid_flush(if1), .idex_bubble(ib1),
        .exmem_flush(ef1), .stall_cycles(sc1), .flush_events(fe1));

    hazard_flush_controller #(.BRANCH_POLICY(1), .WB_WRITE_FIRST(1), .CNT_W(32)) u2 (
        .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_dest(id_dest), .id_is_ctrl(id_is_ctrl), .pc_src(pc_src),
        .pc_write(pw2), .ifid_write(iw2), .ifid_flush(if2), .idex_bubble(ib2),
        .exmem_flush(ef2), .stall_cycles(sc2), .flush_events(fe2));

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic id_set(input logic urs, input logic [4:0] rs, input logic urt,
                          input logic [4:0] rt, input logic rw, input logic [4:0] dst,
                          input logic ctrl);
        id_uses_rs = urs; id_rs = rs; id_uses_rt = urt; id_rt = rt;
        id_reg_write = rw; id_dest = dst; id_is_ctrl = ctrl;
        #1;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; pc_src = 1'b0;
        id_nop();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        // Reset cycle outputs and cleared counters.
        id_nop();
        chk("reset_ctl_u0", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        chk("reset_ctl_u2", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        tick();
        chk("reset_stall_u0", {29'd0, sc0}, 32'd0);
        chk("reset_flush_u0", {29'd0, fe0}, 32'd0);
        Reset = 1'b0;

        // lw $8 then add $9,$8,$8: two stall cycles.
        id_set(1'b1, 5'd29, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        chk("A_lw_issue", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        tick();
        id_set(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0);
        chk("A_stall1", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_STALL});
        tick();
        chk("A_stall2", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_STALL});
        tick();
        chk("A_issue", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        chk("A_stall_cnt", {29'd0, sc0}, 32'd2);
        tick();

        // One independent instruction between producer and consumer: one stall.
        id_set(1'b1, 5'd29, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        tick();
        id_set(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b0);
        chk("B_indep", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        tick();
        id_set(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0);
        chk("B_stall1", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_STALL});
        tick();
        chk("B_issue", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        chk("B_stall_cnt", {29'd0, sc0}, 32'd3);
        tick();
        // Writer of $0 followed by a reader of $0: never a hazard.
        id_set(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        tick();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0);
        chk("B_zero_reader", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        tick();
        chk("B_zero_cnt", {29'd0, sc0}, 32'd3);

        // Squash policy: taken beq with a RAW hazard in ID at the same time.
        do_reset();
        id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1);
        tick();
        id_set(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b0);
        tick();
        pc_src = 1'b1;
        id_set(1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
        chk("C_squash", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_SQ});
        tick();
        pc_src = 1'b0;
        #1;
        chk("C_no_stall_cnt", {29'd0, sc0}, 32'd0);
        chk("C_flush_cnt", {29'd0, fe0}, 32'd1);
        chk("C_slots_cleared", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        tick();

        // jal resolves, jr $31 follows: $31 survives in wb.
        do_reset();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1);
        tick();
        id_nop();
        tick();
        pc_src = 1'b1;
        #1;
        chk("D_jal_squash", {27'd0, pw1, iw1, if1, ib1, ef1}, {27'd0, C_SQ});
        tick();
        pc_src = 1'b0;
        id_set(1'b1, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        chk("D_jr_stall_wbcheck", {27'd0, pw1, iw1, if1, ib1, ef1}, {27'd0, C_STALL});
        chk("D_jr_nostall_wbfirst", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_RUN});
        tick();
        chk("D_jr_issue", {27'd0, pw1, iw1, if1, ib1, ef1}, {27'd0, C_RUN});
        chk("D_stall_cnt", sc1, 32'd1);
        chk("D_flush_cnt", fe1, 32'd1);
        tick();

        // Freeze policy: not-taken then taken branch.
        do_reset();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        tick();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        chk("E_nt_issue", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_FRZ});
        tick();
        id_set(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        chk("E_nt_wait_ignores_raw", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_FRZ});
        tick();
        id_nop();
        chk("E_nt_resolve", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        tick();
        id_set(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        chk("E_nt_run", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        chk("E_nt_flush_cnt", fe2, 32'd0);
        chk("E_nt_stall_cnt", sc2, 32'd0);
        tick();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        chk("E_tk_issue", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_FRZ});
        tick();
        id_nop();
        chk("E_tk_wait", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_FRZ});
        tick();
        pc_src = 1'b1;
        #1;
        chk("E_tk_resolve", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_TAKEN});
        tick();
        pc_src = 1'b0;
        #1;
        chk("E_tk_run", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        chk("E_tk_flush_cnt", fe2, 32'd1);
        tick();

        // Reset while in WAIT with a full scoreboard.
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        tick();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        tick();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1);
        chk("F_enter_wait", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_FRZ});
        tick();
        Reset = 1'b1;
        id_set(1'b1, 5'd9, 1'b1, 5'd31, 1'b1, 5'd5, 1'b0);
        chk("F_reset_ctl", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        tick();
        Reset = 1'b0;
        #1;
        chk("F_after_reset_ctl", {27'd0, pw2, iw2, if2, ib2, ef2}, {27'd0, C_RUN});
        chk("F_after_reset_flush", fe2, 32'd0);
        chk("F_after_reset_stall", sc2, 32'd0);
        tick();

        // Stall counter saturation (3-bit counter on u0).
        do_reset();
        for (int k = 0; k < 4; k++) begin
            id_set(1'b1, 5'd29, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
            tick();
            id_set(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
            tick();
            tick();
            tick();
        end
        chk("G_saturated", {29'd0, sc0}, 32'd7);
        id_set(1'b1, 5'd29, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        tick();
        id_set(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        chk("G_stall_at_max", {27'd0, pw0, iw0, if0, ib0, ef0}, {27'd0, C_STALL});
        tick();
        chk("G_holds_max", {29'd0, sc0}, 32'd7);
        tick();
        tick();
        id_nop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
